// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// HEAD drives the outputs and SKID catches the one entry that arrives during a
// downstream stall. A flush drops every held entry, and the memory strobes and
// the forwarding valid are gated by valid_o, so a bubble never touches memory.
module ex_mem_skid_stage #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int WB_W         = 2,
   parameter int MEM_W        = 3,
   parameter int REGWRITE_BIT = 0,
   parameter int MEMREAD_BIT  = 0,
   parameter int MEMWRITE_BIT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [WB_W-1:0]   wb_i,
   input  logic [MEM_W-1:0]  mem_i,
   input  logic [DATA_W-1:0] result_i,
   input  logic [DATA_W-1:0] rtdata_i,
   input  logic [ADDR_W-1:0] writeaddr_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [WB_W-1:0]   wb_o,
   output logic [MEM_W-1:0]  mem_o,
   output logic [DATA_W-1:0] result_o,
   output logic [DATA_W-1:0] rtdata_o,
   output logic [ADDR_W-1:0] writeaddr_o,
   output logic              memread_o,
   output logic              memwrite_o,
   output logic              fwd_valid_o,
   output logic [ADDR_W-1:0] fwd_addr_o,
   output logic [DATA_W-1:0] fwd_data_o
);

   localparam int PAY_W = WB_W + MEM_W + DATA_W + DATA_W + ADDR_W;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t           state;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] head_p0;
   logic [PAY_W-1:0] skid_p1;
   logic             in_fire;
   logic             out_fire;

   // Payload travels as one packed word so HEAD and SKID move every field together.
   assign in_pay = {wb_i, mem_i, result_i, rtdata_i, writeaddr_i};
   assign {wb_o, mem_o, result_o, rtdata_o, writeaddr_o} = head_p0;

   // Handshake status comes from state alone, so ready_o has no combinational input path.
   assign valid_o  = (state != EMPTY);
   assign ready_o  = (state != FULL);
   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_o & ready_i;

   // Side-effect strobes and forwarding are qualified so stale payload in a bubble is inert.
   assign memread_o   = valid_o & mem_o[MEMREAD_BIT];
   assign memwrite_o  = valid_o & mem_o[MEMWRITE_BIT];
   assign fwd_valid_o = valid_o & wb_o[REGWRITE_BIT] & (writeaddr_o != '0);
   assign fwd_addr_o  = writeaddr_o;
   assign fwd_data_o  = result_o;

   // Occupancy FSM: reset beats flush, and flush beats any handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= EMPTY;
      end else if (flush_i) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) state <= ONE;
            ONE: begin
               if (in_fire && !out_fire)      state <= FULL;
               else if (!in_fire && out_fire) state <= EMPTY;
            end
            FULL: if (out_fire) state <= ONE;
            default: state <= EMPTY;
         endcase
      end
   end

   // HEAD/SKID data movement; a flush leaves stale payload behind, masked by valid_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_p0 <= '0;
         skid_p1 <= '0;
      end else if (!flush_i) begin
         case (state)
            EMPTY: if (in_fire) head_p0 <= in_pay;
            ONE: begin
               if (in_fire && out_fire) head_p0 <= in_pay;
               else if (in_fire)        skid_p1 <= in_pay;
            end
            FULL: if (out_fire) head_p0 <= skid_p1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: a vector table of one-cycle steps with
// hand-computed expected outputs, followed by a multi-cycle stall/drain sequence.
module tb_ex_mem_skid_stage;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [1:0]  wb_i = '0;
   logic [2:0]  mem_i = '0;
   logic [31:0] result_i = '0;
   logic [31:0] rtdata_i = '0;
   logic [4:0]  writeaddr_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [1:0]  wb_o;
   logic [2:0]  mem_o;
   logic [31:0] result_o;
   logic [31:0] rtdata_o;
   logic [4:0]  writeaddr_o;
   logic        memread_o;
   logic        memwrite_o;
   logic        fwd_valid_o;
   logic [4:0]  fwd_addr_o;
   logic [31:0] fwd_data_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_mem_skid_stage dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .wb_i        (wb_i),
      .mem_i       (mem_i),
      .result_i    (result_i),
      .rtdata_i    (rtdata_i),
      .writeaddr_i (writeaddr_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .wb_o        (wb_o),
      .mem_o       (mem_o),
      .result_o    (result_o),
      .rtdata_o    (rtdata_o),
      .writeaddr_o (writeaddr_o),
      .memread_o   (memread_o),
      .memwrite_o  (memwrite_o),
      .fwd_valid_o (fwd_valid_o),
      .fwd_addr_o  (fwd_addr_o),
      .fwd_data_o  (fwd_data_o)
   );

   typedef struct {
      logic        rst, flush, vin, rdy;
      logic [1:0]  wb;
      logic [2:0]  mem;
      logic [31:0] res, rt;
      logic [4:0]  wa;
      logic        vo, ro;
      logic [1:0]  ewb;
      logic [2:0]  emem;
      logic [31:0] eres, ert;
      logic [4:0]  ewa;
      logic        emr, emw, efv;
   } vec_t;

   localparam int NVEC = 26;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input int rst, input int flush, input int vin, input int rdy,
                               input int wb, input int mem, input int res, input int rt, input int wa,
                               input int vo, input int ro, input int ewb, input int emem,
                               input int eres, input int ert, input int ewa,
                               input int emr, input int emw, input int efv);
      vec_t v;
      v.rst = rst[0];  v.flush = flush[0]; v.vin = vin[0]; v.rdy = rdy[0];
      v.wb = wb[1:0];  v.mem = mem[2:0];   v.res = 32'(res); v.rt = 32'(rt); v.wa = wa[4:0];
      v.vo = vo[0];    v.ro = ro[0];       v.ewb = ewb[1:0]; v.emem = emem[2:0];
      v.eres = 32'(eres); v.ert = 32'(ert); v.ewa = ewa[4:0];
      v.emr = emr[0];  v.emw = emw[0];     v.efv = efv[0];
      return v;
   endfunction

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d actual %h required %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic flush, input logic vin, input logic rdy,
                        input logic [1:0] wb, input logic [2:0] mem,
                        input logic [31:0] res, input logic [31:0] rt, input logic [4:0] wa);
      rst_i = rst; flush_i = flush; valid_i = vin; ready_i = rdy;
      wb_i = wb; mem_i = mem; result_i = res; rtdata_i = rt; writeaddr_i = wa;
   endtask

   task automatic check_outs(input int idx, input logic vo, input logic ro, input logic [1:0] ewb,
                             input logic [2:0] emem, input logic [31:0] eres, input logic [31:0] ert,
                             input logic [4:0] ewa, input logic emr, input logic emw, input logic efv);
      check("valid_o",     idx, 32'(valid_o),     32'(vo));
      check("ready_o",     idx, 32'(ready_o),     32'(ro));
      check("wb_o",        idx, 32'(wb_o),        32'(ewb));
      check("mem_o",       idx, 32'(mem_o),       32'(emem));
      check("result_o",    idx, result_o,         eres);
      check("rtdata_o",    idx, rtdata_o,         ert);
      check("writeaddr_o", idx, 32'(writeaddr_o), 32'(ewa));
      check("memread_o",   idx, 32'(memread_o),   32'(emr));
      check("memwrite_o",  idx, 32'(memwrite_o),  32'(emw));
      check("fwd_valid_o", idx, 32'(fwd_valid_o), 32'(efv));
      check("fwd_addr_o",  idx, 32'(fwd_addr_o),  32'(ewa));
      check("fwd_data_o",  idx, fwd_data_o,       eres);
   endtask

   initial begin
      //              rst fl vin rdy wb mem res      rt       wa | vo ro ewb emem eres     ert      ewa mr mw fv
      vecs[0]  = mk(1, 0, 0, 0, 0, 0, 'h0,    'h0,    0,   0, 1, 0, 0, 'h0,    'h0,    0,  0, 0, 0);
      vecs[1]  = mk(0, 0, 1, 1, 0, 0, 'h1234, 'hABCD, 0,   1, 1, 0, 0, 'h1234, 'hABCD, 0,  0, 0, 0);
      vecs[2]  = mk(0, 0, 0, 1, 0, 0, 'h0,    'h0,    0,   0, 1, 0, 0, 'h1234, 'hABCD, 0,  0, 0, 0);
      // stream wa 1..4 with one stall cycle
      vecs[3]  = mk(0, 0, 1, 1, 1, 0, 'h101,  'h5001, 1,   1, 1, 1, 0, 'h101,  'h5001, 1,  0, 0, 1);
      vecs[4]  = mk(0, 0, 1, 0, 1, 0, 'h102,  'h5002, 2,   1, 0, 1, 0, 'h101,  'h5001, 1,  0, 0, 1);
      vecs[5]  = mk(0, 0, 1, 1, 1, 0, 'h103,  'h5003, 3,   1, 1, 1, 0, 'h102,  'h5002, 2,  0, 0, 1);
      vecs[6]  = mk(0, 0, 1, 1, 1, 0, 'h103,  'h5003, 3,   1, 1, 1, 0, 'h103,  'h5003, 3,  0, 0, 1);
      vecs[7]  = mk(0, 0, 1, 1, 1, 0, 'h104,  'h5004, 4,   1, 1, 1, 0, 'h104,  'h5004, 4,  0, 0, 1);
      vecs[8]  = mk(0, 0, 0, 1, 0, 0, 'h0,    'h0,    0,   0, 1, 1, 0, 'h104,  'h5004, 4,  0, 0, 0);
      // fill FULL, then flush with a valid input pending
      vecs[9]  = mk(0, 0, 1, 0, 1, 0, 'h106,  'h5006, 6,   1, 1, 1, 0, 'h106,  'h5006, 6,  0, 0, 1);
      vecs[10] = mk(0, 0, 1, 0, 1, 0, 'h107,  'h5007, 7,   1, 0, 1, 0, 'h106,  'h5006, 6,  0, 0, 1);
      vecs[11] = mk(0, 1, 1, 0, 1, 0, 'h108,  'h5008, 8,   0, 1, 1, 0, 'h106,  'h5006, 6,  0, 0, 0);
      vecs[12] = mk(0, 0, 0, 1, 0, 0, 'h0,    'h0,    0,   0, 1, 1, 0, 'h106,  'h5006, 6,  0, 0, 0);
      // flush in ONE with a concurrent accepted input: input is dropped
      vecs[13] = mk(0, 0, 1, 0, 1, 0, 'h109,  'h5009, 9,   1, 1, 1, 0, 'h109,  'h5009, 9,  0, 0, 1);
      vecs[14] = mk(0, 1, 1, 1, 1, 0, 'h10A,  'h500A, 10,  0, 1, 1, 0, 'h109,  'h5009, 9,  0, 0, 0);
      vecs[15] = mk(0, 0, 0, 1, 0, 0, 'h0,    'h0,    0,   0, 1, 1, 0, 'h109,  'h5009, 9,  0, 0, 0);
      // store strobe gating, then load strobe
      vecs[16] = mk(0, 0, 1, 1, 0, 2, 'h200,  'h55,   0,   1, 1, 0, 2, 'h200,  'h55,   0,  0, 1, 0);
      vecs[17] = mk(0, 0, 0, 1, 0, 2, 'h0,    'h0,    0,   0, 1, 0, 2, 'h200,  'h55,   0,  0, 0, 0);
      vecs[18] = mk(0, 0, 1, 1, 0, 1, 'h300,  'h66,   0,   1, 1, 0, 1, 'h300,  'h66,   0,  1, 0, 0);
      vecs[19] = mk(0, 0, 0, 1, 0, 0, 'h0,    'h0,    0,   0, 1, 0, 1, 'h300,  'h66,   0,  0, 0, 0);
      // forwarding qualification
      vecs[20] = mk(0, 0, 1, 1, 1, 0, 'h400,  'h77,   0,   1, 1, 1, 0, 'h400,  'h77,   0,  0, 0, 0);
      vecs[21] = mk(0, 0, 1, 1, 1, 0, 'h500,  'h88,   5,   1, 1, 1, 0, 'h500,  'h88,   5,  0, 0, 1);
      vecs[22] = mk(0, 0, 1, 1, 0, 0, 'h600,  'h99,   5,   1, 1, 0, 0, 'h600,  'h99,   5,  0, 0, 0);
      // reach FULL then reset together with flush
      vecs[23] = mk(0, 0, 1, 0, 1, 3, 'h111,  'h5011, 11,  1, 0, 0, 0, 'h600,  'h99,   5,  0, 0, 0);
      vecs[24] = mk(1, 1, 1, 1, 1, 3, 'h112,  'h5012, 12,  0, 1, 0, 0, 'h0,    'h0,    0,  0, 0, 0);
      vecs[25] = mk(0, 0, 0, 1, 0, 0, 'h0,    'h0,    0,   0, 1, 0, 0, 'h0,    'h0,    0,  0, 0, 0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].rst, vecs[i].flush, vecs[i].vin, vecs[i].rdy, vecs[i].wb, vecs[i].mem,
               vecs[i].res, vecs[i].rt, vecs[i].wa);
         @(posedge clk);
         #1;
         check_outs(i, vecs[i].vo, vecs[i].ro, vecs[i].ewb, vecs[i].emem, vecs[i].eres,
                    vecs[i].ert, vecs[i].ewa, vecs[i].emr, vecs[i].emw, vecs[i].efv);
      end

      // Long stall: two entries held for several cycles, head must stay stable, then drain in order.
      drive(0, 0, 1, 0, 2'd1, 3'd2, 32'h0000_0D0D, 32'hCAFE_0013, 5'd13);
      @(posedge clk); #1;
      check_outs(100, 1, 1, 2'd1, 3'd2, 32'h0000_0D0D, 32'hCAFE_0013, 5'd13, 0, 1, 1);
      drive(0, 0, 1, 0, 2'd0, 3'd1, 32'h0000_0E0E, 32'hCAFE_0014, 5'd14);
      @(posedge clk); #1;
      check_outs(101, 1, 0, 2'd1, 3'd2, 32'h0000_0D0D, 32'hCAFE_0013, 5'd13, 0, 1, 1);
      drive(0, 0, 1, 0, 2'd1, 3'd0, 32'h0000_0F0F, 32'hCAFE_0015, 5'd15);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check_outs(102 + k, 1, 0, 2'd1, 3'd2, 32'h0000_0D0D, 32'hCAFE_0013, 5'd13, 0, 1, 1);
      end
      drive(0, 0, 0, 1, 2'd0, 3'd0, 32'h0, 32'h0, 5'd0);
      @(posedge clk); #1;
      check_outs(105, 1, 1, 2'd0, 3'd1, 32'h0000_0E0E, 32'hCAFE_0014, 5'd14, 1, 0, 0);
      @(posedge clk); #1;
      check_outs(106, 0, 1, 2'd0, 3'd1, 32'h0000_0E0E, 32'hCAFE_0014, 5'd14, 0, 0, 0);
      @(posedge clk); #1;
      check_outs(107, 0, 1, 2'd0, 3'd1, 32'h0000_0E0E, 32'hCAFE_0014, 5'd14, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
